reg_write_sched: RTL and testbench



---
 rtl/reg_write_pkg.sv | 21 ++
 rtl/reg_write_sched_wr_fifo.sv | 71 +++++++
 rtl/reg_write_sched.sv | 97 +++++++++
 tb/tb_reg_write_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_pkg.sv
// Shared types for the register-write scheduler: request entry layout and issue FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package reg_write_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } sched_state_t;

endpackage

// File: rtl/reg_write_sched_wr_fifo.sv
// In-order synchronous FIFO of wr_req_t entries with flush, full/empty and occupancy.
// Latency: an entry pushed at edge k is visible at pop_dat after edge k; no same-edge bypass.
// Backpressure: pushes while full and pops while empty are ignored; flush overrides both.
module wr_fifo
    import reg_write_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wr_req_t                push_dat,
    input  logic                   pop,
    output wr_req_t                pop_dat,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    wr_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign pop_dat = mem_q[rd_ptr_q[IW-1:0]];

    always_comb begin
        push_ok  = push && !full && !flush;
        pop_ok   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[IW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/reg_write_sched.sv
// Register-write scheduler feeding the 5-to-32 select decoder; REG_WRITE_SCHED_R0_FILTER_EN drops writes to r0.
// Latency: request accepted at edge k issues (enable=1) in the cycle after edge k+1; one write/cycle sustained.
// Backpressure: req_ready = !full && rst_n (no same-cycle refill when full); stall holds issue; flush empties.
module reg_write_sched #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [reg_write_pkg::ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]                req_data,
    input  logic                             flush,
    input  logic                             stall,
    output logic [reg_write_pkg::ADDR_W-1:0] selector,
    output logic                             enable,
    output logic [DATA_W-1:0]                wr_data,
    output logic [$clog2(DEPTH):0]           count
);

    import reg_write_pkg::*;

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] selector_q, selector_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              addr_ok;
    logic              push_vld;
    logic              pop_vld;
    wr_req_t           push_dat;
    wr_req_t           head_dat;

`ifdef REG_WRITE_SCHED_R0_FILTER_EN
    // r0 writes still handshake so the producer never blocks on them.
    assign addr_ok = (req_addr != '0);
`else
    assign addr_ok = 1'b1;
`endif

    assign req_ready = !fifo_full && rst_n;
    assign push_vld  = req_valid && req_ready && addr_ok && !flush;
    assign push_dat  = '{addr: req_addr, data: req_data};

    wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop_vld),
        .pop_dat  (head_dat),
        .flush    (flush),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    always_comb begin
        state_d    = IDLE;
        selector_d = selector_q;
        wr_data_d  = wr_data_q;
        pop_vld    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else if (stall) begin
            state_d = fifo_empty ? IDLE : HOLD;
        end else if (!fifo_empty) begin
            state_d = ISSUE;
        end
        // Entering ISSUE is the pop: the head moves into the output registers at this edge.
        if (state_d == ISSUE) begin
            pop_vld    = 1'b1;
            selector_d = head_dat.addr;
            wr_data_d  = head_dat.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            selector_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            selector_q <= selector_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign enable   = (state_q == ISSUE);
    assign selector = selector_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: directed vector table, hand sequences for wrap/filter, and a
// randomized run checked against a queue-based reference model.
module tb_reg_write_sched;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n, req_valid, flush, stall;
    logic          req_ready, enable;
    logic [4:0]    req_addr, selector;
    logic [31:0]   req_data, wr_data;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    reg_write_sched #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .flush     (flush),
        .stall     (stall),
        .selector  (selector),
        .enable    (enable),
        .wr_data   (wr_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          rn, vld, fl, st;
        logic [4:0]  a;
        logic [31:0] d;
        bit          rdy, en;
        logic [4:0]  sel;
        logic [31:0] wd;
        int          cnt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t        vecs[$];
    ent_t        mq[$];
    bit          m_en;
    logic [4:0]  m_sel;
    logic [31:0] m_wd;

    function automatic vec_t v(input string nm, input bit rn, input bit vld, input bit fl,
                               input bit st, input logic [4:0] a, input logic [31:0] d,
                               input bit rdy, input bit en, input logic [4:0] sel,
                               input logic [31:0] wd, input int cnt);
        vec_t r;
        r.nm = nm; r.rn = rn; r.vld = vld; r.fl = fl; r.st = st; r.a = a; r.d = d;
        r.rdy = rdy; r.en = en; r.sel = sel; r.wd = wd; r.cnt = cnt;
        return r;
    endfunction

    function automatic bit filtered(input logic [4:0] a);
`ifdef REG_WRITE_SCHED_R0_FILTER_EN
        return a == 5'd0;
`else
        return a == 5'd31 && a == 5'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit vld, input bit fl, input bit st,
                         input logic [4:0] a, input logic [31:0] d);
        rst_n = rn; req_valid = vld; flush = fl; stall = st; req_addr = a; req_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pending writes are a plain queue; each edge pops the head (unless stalled,
    // flushed or reset) and appends an accepted request behind it.
    task automatic model_edge();
        bit   rdy;
        ent_t h;
        rdy = rst_n && (mq.size() < DEPTH);
        if (!rst_n) begin
            mq.delete(); m_en = 0; m_sel = '0; m_wd = '0;
        end else if (flush) begin
            mq.delete(); m_en = 0;
        end else begin
            m_en = 0;
            if (!stall && mq.size() > 0) begin
                h = mq.pop_front(); m_en = 1; m_sel = h.a; m_wd = h.d;
            end
            if (req_valid && rdy && !filtered(req_addr)) mq.push_back('{a: req_addr, d: req_data});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pushed, issued, first_iss, last_iss, ucyc, maxc;
        int          rec[2];
        bit          acc;
        ent_t        got[$];
        ent_t        exp_q[$];

        drive(0, 0, 0, 0, 0, 0);

        // name, rst_n, vld, flush, stall, addr, data | ready, enable, selector, wr_data, count
        vecs.push_back(v("rst0",    0,0,0,0, 5'd0,  32'h0,         0,0,5'd0, 32'h0,         0));
        vecs.push_back(v("rst1",    0,0,0,0, 5'd0,  32'h0,         0,0,5'd0, 32'h0,         0));
        vecs.push_back(v("release", 1,0,0,0, 5'd0,  32'h0,         1,0,5'd0, 32'h0,         0));
        vecs.push_back(v("push4",   1,1,0,0, 5'd4,  32'hA5A5_0004, 1,0,5'd0, 32'h0,         1));
        vecs.push_back(v("push13",  1,1,0,0, 5'd13, 32'h0000_000D, 1,1,5'd4, 32'hA5A5_0004, 1));
        vecs.push_back(v("iss13",   1,0,0,0, 5'd0,  32'h0,         1,1,5'd13,32'h0000_000D, 0));
        vecs.push_back(v("keep13",  1,0,0,0, 5'd0,  32'h0,         1,0,5'd13,32'h0000_000D, 0));
        vecs.push_back(v("sfill1",  1,1,0,1, 5'd1,  32'h101,       1,0,5'd13,32'h0000_000D, 1));
        vecs.push_back(v("sfill2",  1,1,0,1, 5'd2,  32'h102,       1,0,5'd13,32'h0000_000D, 2));
        vecs.push_back(v("sfill3",  1,1,0,1, 5'd3,  32'h103,       1,0,5'd13,32'h0000_000D, 3));
        vecs.push_back(v("sfill4",  1,1,0,1, 5'd6,  32'h106,       0,0,5'd13,32'h0000_000D, 4));
        vecs.push_back(v("sfill5",  1,1,0,1, 5'd9,  32'h109,       0,0,5'd13,32'h0000_000D, 4));
        vecs.push_back(v("drain1",  1,0,0,0, 5'd0,  32'h0,         1,1,5'd1, 32'h101,       3));
        vecs.push_back(v("drain2",  1,0,0,0, 5'd0,  32'h0,         1,1,5'd2, 32'h102,       2));
        vecs.push_back(v("drain3",  1,0,0,0, 5'd0,  32'h0,         1,1,5'd3, 32'h103,       1));
        vecs.push_back(v("drain4",  1,0,0,0, 5'd0,  32'h0,         1,1,5'd6, 32'h106,       0));
        vecs.push_back(v("drained", 1,0,0,0, 5'd0,  32'h0,         1,0,5'd6, 32'h106,       0));
        vecs.push_back(v("fpush10", 1,1,0,1, 5'd10, 32'h10A,       1,0,5'd6, 32'h106,       1));
        vecs.push_back(v("fpush11", 1,1,0,1, 5'd11, 32'h10B,       1,0,5'd6, 32'h106,       2));
        vecs.push_back(v("fpush12", 1,1,0,1, 5'd12, 32'h10C,       1,0,5'd6, 32'h106,       3));
        vecs.push_back(v("flush14", 1,1,1,0, 5'd14, 32'h10E,       1,0,5'd6, 32'h106,       0));
        vecs.push_back(v("postfl",  1,0,0,0, 5'd0,  32'h0,         1,0,5'd6, 32'h106,       0));
        vecs.push_back(v("push20",  1,1,0,0, 5'd20, 32'h114,       1,0,5'd6, 32'h106,       1));
        vecs.push_back(v("push21",  1,1,0,0, 5'd21, 32'h115,       1,1,5'd20,32'h114,       1));
        vecs.push_back(v("rstmid",  0,0,0,0, 5'd0,  32'h0,         0,0,5'd0, 32'h0,         0));
        vecs.push_back(v("rel2",    1,0,0,0, 5'd0,  32'h0,         1,0,5'd0, 32'h0,         0));

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].vld, vecs[i].fl, vecs[i].st, vecs[i].a, vecs[i].d);
            tick();
            chk({vecs[i].nm, ".ready"},    64'(req_ready), 64'(vecs[i].rdy));
            chk({vecs[i].nm, ".enable"},   64'(enable),    64'(vecs[i].en));
            chk({vecs[i].nm, ".selector"}, 64'(selector),  64'(vecs[i].sel));
            chk({vecs[i].nm, ".wr_data"},  64'(wr_data),   64'(vecs[i].wd));
            chk({vecs[i].nm, ".count"},    64'(count),     64'(vecs[i].cnt));
        end

        // Fill while stalled, then release with req_valid held: 20 writes through the pointer wrap.
        pushed = 0; issued = 0; first_iss = -1; last_iss = -1; ucyc = 0; maxc = 0;
        rec[0] = -1; rec[1] = -1;
        for (int cyc = 0; cyc < 300 && issued < 20; cyc++) begin
            drive(1, pushed < 20, 0, pushed < DEPTH, 5'((pushed % 31) + 1), 32'hC000_0000 + pushed);
            acc = req_valid && req_ready;
            tick();
            if (acc) pushed++;
            if (!stall && ucyc < 2) begin
                rec[ucyc] = int'(count);
                ucyc++;
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (enable) begin
                got.push_back('{a: selector, d: wr_data});
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                issued++;
            end
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("wrap.issued_all", 64'(issued), 64'd20);
        chk("wrap.max_count", 64'(maxc), 64'(DEPTH));
        chk("wrap.no_refill_when_full", 64'(rec[0]), 64'(DEPTH - 1));
        chk("wrap.refill_next_cycle", 64'(rec[1]), 64'(DEPTH - 1));
        chk("wrap.back_to_back", 64'(last_iss - first_iss + 1), 64'd20);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("wrap.order%0d", i), 64'(got[i]),
                64'({5'((i % 31) + 1), 32'hC000_0000 + 32'(i)}));
        end

        // Address 0 followed by address 7.
        for (int i = 0; i < 3; i++) tick();
        got.delete(); maxc = 0;
`ifdef REG_WRITE_SCHED_R0_FILTER_EN
        exp_q.push_back('{a: 5'd7, d: 32'hF7});
`else
        exp_q.push_back('{a: 5'd0, d: 32'hF0});
        exp_q.push_back('{a: 5'd7, d: 32'hF7});
`endif
        drive(1, 1, 0, 0, 5'd0, 32'hF0);
        chk("r0.ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) drive(1, 1, 0, 0, 5'd7, 32'hF7);
            else drive(1, 0, 0, 0, 0, 0);
            if (int'(count) > maxc) maxc = int'(count);
            if (enable) got.push_back('{a: selector, d: wr_data});
        end
        chk("r0.peak_count", 64'(maxc), 64'd1);
        chk("r0.issue_count", 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("r0.issue%0d", i), 64'(got[i]), 64'(exp_q[i]));
        end

        // Randomized traffic against the queue model, starting from a reset edge.
        drive(0, 0, 0, 0, 0, 0);
        model_edge();
        tick();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)), $urandom);
            model_edge();
            tick();
            chk($sformatf("rand%0d.enable", c),   64'(enable),    64'(m_en));
            chk($sformatf("rand%0d.selector", c), 64'(selector),  64'(m_sel));
            chk($sformatf("rand%0d.wr_data", c),  64'(wr_data),   64'(m_wd));
            chk($sformatf("rand%0d.count", c),    64'(count),     64'(mq.size()));
            chk($sformatf("rand%0d.ready", c),    64'(req_ready), 64'(rst_n && (mq.size() < DEPTH)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
